// File: rtl/mux_pkg.sv
// Shared constants for the 1-master / N-slave request router.
// State codes are plain localparams so the encoding stays readable in legacy tools and waveforms.
package mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;
  localparam state_t S_ERR  = 2'd3;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic is_read(input logic cmd);
    return cmd == CMD_RD;
  endfunction

endpackage

// File: rtl/mux_tmo_counter.sv
// WAIT-state watchdog: counts enabled cycles and flags the cycle whose count equals the limit.
// With ENABLE=0 the expired flag is constant 0, so a stalled slave is waited on forever.
module mux_tmo_counter #(
  parameter int unsigned CW     = 8,
  parameter bit          ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic          expired_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = ENABLE && en_i && (count_q == limit_i);

endmodule

// File: rtl/mux_n_slaves.sv
// Registered 1-master to N-slave router: decodes the top address bits, forwards one request,
// and returns ack/rdata, or an error response on decode failure or slave timeout.
module mux_n_slaves
  import mux_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   NS       = 4,
  parameter int unsigned   SEL_W    = $clog2(NS),
  parameter int unsigned   TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   master_req,
  input  logic [AW-1:0]          master_addr,
  input  logic                   master_cmd,
  input  logic [DW-1:0]          master_wdata,
  output logic                   master_ack,
  output logic [DW-1:0]          master_rdata,
  output logic                   master_err,
  output logic [NS-1:0]          slave_req,
  output logic [NS-1:0][AW-1:0]  slave_addr,
  output logic [NS-1:0]          slave_cmd,
  output logic [NS-1:0][DW-1:0]  slave_wdata,
  input  logic [NS-1:0]          slave_ack,
  input  logic [NS-1:0][DW-1:0]  slave_rdata,
  output logic [7:0]             err_count
);

  localparam int unsigned TMO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned TMO_W   = (TMO_LIM == 0) ? 1 : $clog2(TMO_LIM + 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              cmd_q, cmd_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic [SEL_W-1:0]  master_sel;
  logic              sel_ok;
  logic [NS-1:0]     sel_oh;
  logic              ack_hit;
  logic [DW-1:0]     rd_mux;
  logic              tmo_expired;

  logic                  master_ack_d, master_err_d;
  logic [DW-1:0]         master_rdata_d;
  logic [NS-1:0]         slave_req_d, slave_cmd_d;
  logic [NS-1:0][AW-1:0] slave_addr_d;
  logic [NS-1:0][DW-1:0] slave_wdata_d;
  logic [7:0]            err_count_d;

  assign master_sel = master_addr[AW-1 -: SEL_W];
  assign sel_ok     = (32'(master_sel) < NS);

  // Acks and read data from slaves other than the latched one never reach the FSM.
  always_comb begin
    sel_oh = '0;
    rd_mux = '0;
    for (int i = 0; i < NS; i++) begin
      sel_oh[i] = (sel_q == SEL_W'(i));
      if (sel_oh[i]) rd_mux = slave_rdata[i];
    end
  end

  assign ack_hit = |(slave_ack & sel_oh);

  mux_tmo_counter #(
    .CW     (TMO_W),
    .ENABLE (TIMEOUT != 0)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != S_WAIT),
    .en_i      (state_q == S_WAIT),
    .limit_i   (TMO_W'(TMO_LIM)),
    .expired_o (tmo_expired)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (master_req) begin
          addr_d  = master_addr;
          cmd_d   = master_cmd;
          wdata_d = master_wdata;
          sel_d   = master_sel;
          state_d = sel_ok ? S_WAIT : S_ERR;
        end
      end
      S_WAIT: begin
        if (ack_hit) begin
          state_d = S_RESP;
        end else if (tmo_expired) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers load from next-state so each output appears in the cycle its state is entered.
  always_comb begin
    master_ack_d   = (state_d == S_RESP) || (state_d == S_ERR);
    master_err_d   = (state_d == S_ERR);
    master_rdata_d = '0;
    if (state_d == S_ERR) begin
      master_rdata_d = ERR_DATA;
    end else if (state_d == S_RESP && is_read(cmd_q)) begin
      master_rdata_d = rd_mux;
    end

    slave_req_d   = '0;
    slave_cmd_d   = '0;
    slave_addr_d  = '0;
    slave_wdata_d = '0;
    for (int i = 0; i < NS; i++) begin
      if (state_d == S_WAIT && sel_d == SEL_W'(i)) begin
        slave_req_d[i]   = 1'b1;
        slave_cmd_d[i]   = cmd_d;
        slave_addr_d[i]  = addr_d;
        slave_wdata_d[i] = wdata_d;
      end
    end

    err_count_d = err_count;
    if (state_d == S_ERR && err_count != 8'hFF) begin
      err_count_d = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_q        <= 1'b0;
      wdata_q      <= '0;
      sel_q        <= '0;
      master_ack   <= 1'b0;
      master_err   <= 1'b0;
      master_rdata <= '0;
      slave_req    <= '0;
      slave_cmd    <= '0;
      slave_addr   <= '0;
      slave_wdata  <= '0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      master_ack   <= master_ack_d;
      master_err   <= master_err_d;
      master_rdata <= master_rdata_d;
      slave_req    <= slave_req_d;
      slave_cmd    <= slave_cmd_d;
      slave_addr   <= slave_addr_d;
      slave_wdata  <= slave_wdata_d;
      err_count    <= err_count_d;
    end
  end

endmodule
